// File: rtl/bus_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, owner IDs,
// default widths and the starvation counter helper.
package bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter. The arbiter uses the
// slave view; whatever drives requests and models the RAM uses the master view.
interface mem_arbiter_if import bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_lock;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/starve_counter.sv
// Counts cycles a DMA request has been refused; saturates at the counter
// maximum and flags when the wait limit is reached.
module starve_counter import bus_pkg::*; #(
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !req_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between the CPU and the display DMA.
// One access per grant, optional CPU bus lock, bounded DMA wait.
module mem_arbiter import bus_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              acc_read_q;
  logic              cpu_gnt_q;
  logic              dma_gnt_q;
  logic              cpu_rvalid_q;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              arb_en;
  logic              locked;
  logic              grant_cpu;
  logic              grant_dma;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              starve_hit;
  logic              starve_clr;
  logic [CNT_W-1:0]  starve_cnt;

  // Arbitration runs in RESP as well as IDLE so a new grant overlaps the
  // previous read response, giving one access every two cycles.
  always_comb begin
    arb_en    = (state_q == IDLE) || (state_q == RESP);
    locked    = bus.cpu_lock && (owner_q == OWNER_CPU);
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (arb_en) begin
      if (locked) begin
        grant_cpu = bus.cpu_req;
      end else if (starve_hit && bus.dma_req) begin
        grant_dma = 1'b1;
      end else if (bus.cpu_req) begin
        grant_cpu = 1'b1;
      end else if (bus.dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  always_comb begin
    win_we    = bus.cpu_we;
    win_addr  = bus.cpu_addr;
    win_wdata = bus.cpu_wdata;
    if (grant_dma) begin
      win_we    = bus.dma_we;
      win_addr  = bus.dma_addr;
      win_wdata = bus.dma_wdata;
    end
  end

  // The gnt cycle also clears so a request still held during it is not counted.
  assign starve_clr = grant_dma || dma_gnt_q;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.dma_req),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt),
    .hit_o (starve_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_CPU;
      acc_read_q   <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          if (acc_read_q) begin
            rdata_q      <= bus.mem_rdata;
            cpu_rvalid_q <= (owner_q == OWNER_CPU);
            dma_rvalid_q <= (owner_q == OWNER_DMA);
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (grant_cpu || grant_dma) begin
        state_q     <= ISSUE;
        owner_q     <= grant_dma ? OWNER_DMA : OWNER_CPU;
        acc_read_q  <= !win_we;
        mem_en_q    <= 1'b1;
        mem_we_q    <= win_we;
        mem_addr_q  <= win_addr;
        mem_wdata_q <= win_wdata;
        cpu_gnt_q   <= grant_cpu;
        dma_gnt_q   <= grant_dma;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.dma_gnt    = dma_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads/writes, back-to-back,
// contention with starvation, CPU lock, and reset in the middle of an access.
module tb_mem_arbiter;
  import bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DW-1:0] ram [0:65535];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with registered read
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_lock  = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_mem_en"},     32'(bus.mem_en), 0);
    check_eq({tag, "_mem_we"},     32'(bus.mem_we), 0);
    check_eq({tag, "_mem_addr"},   32'(bus.mem_addr), 0);
    check_eq({tag, "_mem_wdata"},  32'(bus.mem_wdata), 0);
    check_eq({tag, "_rdata"},      32'(bus.rdata), 0);
    check_eq({tag, "_gnts"},       32'({bus.cpu_gnt, bus.dma_gnt}), 0);
    check_eq({tag, "_rvalids"},    32'({bus.cpu_rvalid, bus.dma_rvalid}), 0);
  endtask

  // Invariants checked every cycle
  always @(negedge clk) begin
    check_eq("gnt_exclusive", 32'(bus.cpu_gnt & bus.dma_gnt), 0);
    check_eq("we_without_en", 32'(bus.mem_we & ~bus.mem_en), 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] b2b_data [4];
    int gidx;
    int ridx;
    bit eg_cpu, eg_dma, ev_cpu, ev_dma;

    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'h5A5A;
    ram[16'h0010] = 16'hBEEF;
    ram[16'h0030] = 16'h3030;
    ram[16'h0040] = 16'h4040;
    ram[16'h0050] = 16'h5050;
    ram[16'h0051] = 16'h5151;
    for (int i = 0; i < 4; i++) begin
      b2b_data[i] = 16'hA000 + 16'(i);
      ram[16'h0020 + 16'(i)] = b2b_data[i];
    end

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("reset_owner", 32'(dut.owner_q), 32'(OWNER_CPU));
    check_eq("reset_starve", 32'(dut.u_starve.cnt_q), 0);
    rst = 1'b1;
    @(negedge clk);

    // CPU read of 0x0010
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    check_eq("rd_cpu_gnt", 32'(bus.cpu_gnt), 1);
    check_eq("rd_dma_gnt", 32'(bus.dma_gnt), 0);
    check_eq("rd_mem_en", 32'(bus.mem_en), 1);
    check_eq("rd_mem_we", 32'(bus.mem_we), 0);
    check_eq("rd_mem_addr", 32'(bus.mem_addr), 32'h0010);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rd_n2_rvalid", 32'(bus.cpu_rvalid), 0);
    check_eq("rd_n2_mem_en", 32'(bus.mem_en), 0);
    check_eq("rd_n2_gnt", 32'(bus.cpu_gnt), 0);
    @(negedge clk);
    check_eq("rd_n3_rvalid", 32'(bus.cpu_rvalid), 1);
    check_eq("rd_n3_rdata", 32'(bus.rdata), 32'hBEEF);
    check_eq("rd_n3_dma_rvalid", 32'(bus.dma_rvalid), 0);
    $display("[%0t] cpu read  addr=0010 data=%h", $time, bus.rdata);
    @(negedge clk);
    check_eq("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 0);

    // DMA write 0x8000 <= 0x1234
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h8000; bus.dma_wdata = 16'h1234;
    @(negedge clk);
    check_eq("wr_dma_gnt", 32'(bus.dma_gnt), 1);
    check_eq("wr_cpu_gnt", 32'(bus.cpu_gnt), 0);
    check_eq("wr_mem_en", 32'(bus.mem_en), 1);
    check_eq("wr_mem_we", 32'(bus.mem_we), 1);
    check_eq("wr_mem_addr", 32'(bus.mem_addr), 32'h8000);
    check_eq("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    @(negedge clk);
    check_eq("wr_n2_mem_we", 32'(bus.mem_we), 0);
    check_eq("wr_n2_mem_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    check_eq("wr_no_dma_rvalid", 32'(bus.dma_rvalid), 0);
    check_eq("wr_no_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    check_eq("wr_ram", 32'(ram[16'h8000]), 32'h1234);
    $display("[%0t] dma write addr=8000 data=%h", $time, ram[16'h8000]);

    // DMA read back
    bus.dma_req = 1'b1; bus.dma_addr = 16'h8000;
    @(negedge clk);
    check_eq("dmard_gnt", 32'(bus.dma_gnt), 1);
    bus.dma_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("dmard_rvalid", 32'(bus.dma_rvalid), 1);
    check_eq("dmard_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    check_eq("dmard_rdata", 32'(bus.rdata), 32'h1234);
    $display("[%0t] dma read  addr=8000 data=%h", $time, bus.rdata);

    // Back-to-back CPU reads 0x20..0x23
    gidx = 0; ridx = 0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      check_eq("b2b_gnt", 32'(bus.cpu_gnt), 32'(cyc == 1 || cyc == 3 || cyc == 5 || cyc == 7));
      check_eq("b2b_rvalid", 32'(bus.cpu_rvalid), 32'(cyc == 3 || cyc == 5 || cyc == 7 || cyc == 9));
      if (bus.cpu_rvalid && ridx < 4) begin
        check_eq("b2b_data", 32'(bus.rdata), 32'(b2b_data[ridx]));
        $display("[%0t] cpu read  addr=%h data=%h", $time, 16'h0020 + 16'(ridx), bus.rdata);
        ridx++;
      end
      if (bus.cpu_gnt) begin
        gidx++;
        if (gidx < 4) bus.cpu_addr = 16'h0020 + 16'(gidx);
        else bus.cpu_req = 1'b0;
      end
    end
    check_eq("b2b_count", 32'(ridx), 4);

    // Contention: both requests held, DMA forced in after MAX_WAIT refusals
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0030;
    bus.dma_req = 1'b1; bus.dma_addr = 16'h0040;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      eg_cpu = (cyc == 1 || cyc == 3 || cyc == 7 || cyc == 9);
      eg_dma = (cyc == 5 || cyc == 11);
      ev_cpu = (cyc == 3 || cyc == 5 || cyc == 9 || cyc == 11);
      ev_dma = (cyc == 7);
      check_eq("cont_cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_cpu));
      check_eq("cont_dma_gnt", 32'(bus.dma_gnt), 32'(eg_dma));
      check_eq("cont_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(ev_cpu));
      check_eq("cont_dma_rvalid", 32'(bus.dma_rvalid), 32'(ev_dma));
      if (ev_cpu) check_eq("cont_cpu_rdata", 32'(bus.rdata), 32'h3030);
      if (ev_dma) check_eq("cont_dma_rdata", 32'(bus.rdata), 32'h4040);
      if (cyc == 4) check_eq("cont_starve_peak", 32'(dut.u_starve.cnt_q), 4);
      if (cyc == 5 || cyc == 6) check_eq("cont_starve_clr", 32'(dut.u_starve.cnt_q), 0);
      if (bus.cpu_gnt) $display("[%0t] contention grant cpu", $time);
      if (bus.dma_gnt) $display("[%0t] contention grant dma", $time);
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    check_eq("mid_pre_gnt", 32'(bus.cpu_gnt), 1);
    check_eq("mid_pre_mem_en", 32'(bus.mem_en), 1);
    bus.cpu_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrst_no_rvalid", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 0);
    end
    check_eq("midrst_state", 32'(dut.state_q), 32'(IDLE));
    $display("[%0t] reset mid-read, access abandoned", $time);

    // CPU lock holds off DMA past MAX_WAIT
    bus.cpu_req = 1'b1; bus.cpu_lock = 1'b1; bus.cpu_addr = 16'h0050;
    bus.dma_req = 1'b1; bus.dma_addr = 16'h0040;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      check_eq("lock_cpu_gnt", 32'(bus.cpu_gnt), 32'(cyc == 1 || cyc == 3));
      check_eq("lock_dma_gnt", 32'(bus.dma_gnt), 0);
      if (cyc == 3) check_eq("lock_rd1", 32'(bus.rdata), 32'h5050);
      if (cyc == 5) check_eq("lock_rd2", 32'(bus.rdata), 32'h5151);
      if (cyc == 8) check_eq("lock_starve", 32'(dut.u_starve.cnt_q), 8);
      if (cyc == 1) bus.cpu_addr = 16'h0051;
      if (cyc == 3) bus.cpu_req = 1'b0;
    end
    bus.cpu_lock = 1'b0;
    @(negedge clk);
    check_eq("unlock_dma_gnt", 32'(bus.dma_gnt), 1);
    check_eq("unlock_cpu_gnt", 32'(bus.cpu_gnt), 0);
    bus.dma_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("unlock_dma_rvalid", 32'(bus.dma_rvalid), 1);
    check_eq("unlock_dma_rdata", 32'(bus.rdata), 32'h4040);
    $display("[%0t] lock released, dma read data=%h", $time, bus.rdata);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
